// File: rtl/ladder_sprite_renderer_pkg.sv
// Shared types and defaults for the ladder overlay stage of the VGA pipeline.
package ladder_sprite_renderer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    SHOWN  = 2'd2
  } ladder_state_t;

  localparam logic [11:0] TRANSPARENT_DEFAULT = 12'hF0F;
  localparam logic [11:0] BLANK_RGB_DEFAULT   = 12'h888;
  localparam int          VER_PIXELS          = 600;
  localparam logic [10:0] REVEAL_MAX          = 11'd1023;

endpackage

// File: rtl/vga_if.sv
// VGA timing plus colour bundle passed between pipeline stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/ladder_sprite_renderer_delay.sv
// Fixed-length shift register used to keep timing aligned with the ROM read.
module ladder_sprite_renderer_delay #(
  parameter int WIDTH   = 39,
  parameter int CLK_DEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_reg [CLK_DEL];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CLK_DEL; i++) pipe_reg[i] <= '0;
    end else begin
      pipe_reg[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign dout = pipe_reg[CLK_DEL-1];

endmodule

// File: rtl/ladder_sprite_renderer.sv
// Ladder overlay: animated, bottom-up revealed, colour-keyed sprites from an
// external synchronous ROM, three-clock latency from in to out.
module ladder_sprite_renderer
  import ladder_sprite_renderer_pkg::*;
#(
  parameter int          NUM_LADDERS = 4,
  parameter int          SPRITE_W    = 32,
  parameter int          SPRITE_H    = 32,
  parameter int          ANIM_FRAMES = 2,
  parameter int          FRAME_DIV   = 8,
  parameter int          REVEAL_STEP = 4,
  parameter logic [11:0] TRANSPARENT = TRANSPARENT_DEFAULT,
  parameter logic [11:0] BLANK_RGB   = BLANK_RGB_DEFAULT,
  localparam int         CW          = $clog2(SPRITE_W),
  localparam int         RW          = $clog2(SPRITE_H),
  localparam int         FW          = $clog2(ANIM_FRAMES),
  localparam int         AW          = FW + RW + CW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_game,
  input  logic [NUM_LADDERS*11-1:0] ladder_x,
  input  logic [NUM_LADDERS*11-1:0] ladder_top,
  input  logic [NUM_LADDERS*11-1:0] ladder_bot,
  input  logic [11:0]              rgb_pixel,
  output logic [AW-1:0]            pixel_addr,
  vga_if.in                        in,
  vga_if.out                       out
);

  localparam int FWS = (FW > 0) ? FW : 1;
  localparam int DW  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int TW  = 39;

  ladder_state_t  state_reg;
  logic [10:0]    reveal_reg;
  logic [FWS-1:0] frame_idx_reg;
  logic [DW-1:0]  div_cnt_reg;
  logic           vsync_reg;
  logic           frame_tick;
  logic [11:0]    reveal_sum;

  assign frame_tick = in.vsync & ~vsync_reg;
  assign reveal_sum = {1'b0, reveal_reg} + 12'(REVEAL_STEP);

  // Animation counters and reveal FSM; dropping start_game wipes all of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_reg     <= 1'b0;
      state_reg     <= IDLE;
      reveal_reg    <= '0;
      frame_idx_reg <= '0;
      div_cnt_reg   <= '0;
    end else begin
      vsync_reg <= in.vsync;
      if (!start_game) begin
        state_reg     <= IDLE;
        reveal_reg    <= '0;
        frame_idx_reg <= '0;
        div_cnt_reg   <= '0;
      end else begin
        if (frame_tick) begin
          if (div_cnt_reg == DW'(FRAME_DIV - 1)) begin
            div_cnt_reg   <= '0;
            frame_idx_reg <= (ANIM_FRAMES > 1) ? frame_idx_reg + 1'b1 : '0;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        case (state_reg)
          IDLE: begin
            reveal_reg <= '0;
            state_reg  <= REVEAL;
          end
          REVEAL: begin
            if (frame_tick) begin
              if (reveal_sum >= 12'd1024) begin
                reveal_reg <= REVEAL_MAX;
                state_reg  <= SHOWN;
              end else begin
                reveal_reg <= reveal_sum[10:0];
              end
            end
          end
          SHOWN:   reveal_reg <= REVEAL_MAX;
          default: state_reg  <= IDLE;
        endcase
      end
    end
  end

  logic [NUM_LADDERS-1:0] hit_vec;
  logic [CW-1:0]          col_vec [NUM_LADDERS];
  logic [RW-1:0]          row_vec [NUM_LADDERS];

  // Lower bound max(top, bot-reveal+1) is tested as vcount+reveal > bot to avoid underflow.
  for (genvar gi = 0; gi < NUM_LADDERS; gi++) begin : g_ladder
    logic [10:0] lx;
    logic [10:0] lt;
    logic [10:0] lb;
    assign lx = ladder_x[11*gi +: 11];
    assign lt = ladder_top[11*gi +: 11];
    assign lb = ladder_bot[11*gi +: 11];
    assign hit_vec[gi] = start_game && (reveal_reg != '0)
                      && (in.hcount >= lx)
                      && ({1'b0, in.hcount} < ({1'b0, lx} + 12'(SPRITE_W)))
                      && (in.vcount >= lt) && (in.vcount <= lb)
                      && (({1'b0, in.vcount} + {1'b0, reveal_reg}) > {1'b0, lb});
    assign col_vec[gi] = in.hcount[CW-1:0] - lx[CW-1:0];
    assign row_vec[gi] = in.vcount[RW-1:0] - lt[RW-1:0];
  end

  logic          hit_any;
  logic [CW-1:0] col_sel;
  logic [RW-1:0] row_sel;
  logic [AW-1:0] addr_next;

  always_comb begin
    hit_any = 1'b0;
    col_sel = '0;
    row_sel = '0;
    for (int i = NUM_LADDERS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        col_sel = col_vec[i];
        row_sel = row_vec[i];
      end
    end
  end

  if (FW > 0) begin : g_frame
    assign addr_next = {frame_idx_reg, row_sel, col_sel};
  end else begin : g_no_frame
    assign addr_next = {row_sel, col_sel};
  end

  always_ff @(posedge clk) begin
    if (rst)          pixel_addr <= '0;
    else if (hit_any) pixel_addr <= addr_next;
  end

  logic [TW-1:0] dly_in;
  logic [TW-1:0] dly_out;
  logic [10:0]   s2_hcount;
  logic [10:0]   s2_vcount;
  logic          s2_hsync;
  logic          s2_vsync;
  logic          s2_hblnk;
  logic          s2_vblnk;
  logic [11:0]   s2_rgb;
  logic          s2_hit;

  assign dly_in = {in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk, in.rgb, hit_any};
  assign {s2_hcount, s2_vcount, s2_hsync, s2_vsync, s2_hblnk, s2_vblnk, s2_rgb, s2_hit} = dly_out;

  ladder_sprite_renderer_delay #(
    .WIDTH   (TW),
    .CLK_DEL (2)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (dly_in),
    .dout (dly_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.hcount <= s2_hcount;
      out.vcount <= s2_vcount;
      out.hsync  <= s2_hsync;
      out.vsync  <= s2_vsync;
      out.hblnk  <= s2_hblnk;
      out.vblnk  <= s2_vblnk;
      if (s2_hblnk || s2_vblnk)                  out.rgb <= BLANK_RGB;
      else if (s2_hit && rgb_pixel != TRANSPARENT) out.rgb <= rgb_pixel;
      else                                       out.rgb <= s2_rgb;
    end
  end

endmodule

// File: tb/tb_ladder_sprite_renderer.sv
// Directed + randomized bench for ladder_sprite_renderer against a cycle-level
// arithmetic model of reveal, animation, hit priority and colour keying.
module tb_ladder_sprite_renderer;
  import ladder_sprite_renderer_pkg::*;

  localparam int          NL       = 4;
  localparam logic [10:0] KEY_ADDR = 11'h105;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_game;
  logic [NL*11-1:0] ladder_x;
  logic [NL*11-1:0] ladder_top;
  logic [NL*11-1:0] ladder_bot;
  logic [11:0]   rgb_pixel;
  logic [10:0]   pixel_addr;

  vga_if vin();
  vga_if vout();

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  int          m_reveal;
  int          m_frame;
  int          m_div;
  bit          m_active;
  bit          m_prev_vs;
  logic [10:0] m_addr;
  logic [37:0] exp_q [$];
  logic [37:0] obs_bus;

  always #5 clk = ~clk;

  ladder_sprite_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .start_game (start_game),
    .ladder_x   (ladder_x),
    .ladder_top (ladder_top),
    .ladder_bot (ladder_bot),
    .rgb_pixel  (rgb_pixel),
    .pixel_addr (pixel_addr),
    .in         (vin),
    .out        (vout)
  );

  assign obs_bus = {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};

  function automatic logic [11:0] rom(input logic [10:0] a);
    return (a == KEY_ADDR) ? 12'hF0F : {1'b0, a};
  endfunction

  // Synchronous sprite ROM: data one clock after the address.
  always @(posedge clk) rgb_pixel <= rom(pixel_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: model predicts from the sampled inputs, then DUT outputs are compared.
  task automatic step();
    bit          s_rst, s_start, s_vs, tick, hit;
    int          h, v, lx, lt, lb, lo;
    logic [10:0] new_addr;
    logic [37:0] rec;
    s_rst = rst; s_start = start_game; s_vs = vin.vsync;
    h = int'(vin.hcount); v = int'(vin.vcount);
    rec = {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, vin.rgb};
    hit = 1'b0; new_addr = m_addr;
    for (int i = 0; i < NL; i++) begin
      lx = int'(ladder_x[11*i +: 11]);
      lt = int'(ladder_top[11*i +: 11]);
      lb = int'(ladder_bot[11*i +: 11]);
      lo = (lb - m_reveal + 1 > lt) ? lb - m_reveal + 1 : lt;
      if (!hit && s_start && m_reveal > 0 && h >= lx && h < lx + 32 && v >= lo && v <= lb) begin
        hit = 1'b1;
        new_addr = 11'(m_frame * 1024 + ((v - lt) % 32) * 32 + (h - lx) % 32);
      end
    end
    if (vin.hblnk || vin.vblnk)              rec[11:0] = BLANK_RGB_DEFAULT;
    else if (hit && rom(new_addr) != 12'hF0F) rec[11:0] = rom(new_addr);
    @(posedge clk); #1;
    if (s_rst) begin
      m_reveal = 0; m_frame = 0; m_div = 0; m_active = 0; m_prev_vs = 0; m_addr = '0;
      exp_q.delete();
      repeat (3) exp_q.push_back('0);
    end else begin
      exp_q.push_back(rec);
      m_addr = new_addr;
      tick = s_vs && !m_prev_vs;
      m_prev_vs = s_vs;
      if (!s_start) begin
        m_reveal = 0; m_frame = 0; m_div = 0; m_active = 0;
      end else begin
        if (tick) begin
          m_div++;
          if (m_div == 8) begin m_div = 0; m_frame = (m_frame + 1) % 2; end
        end
        if (!m_active) m_active = 1;
        else if (tick) m_reveal = (m_reveal + 4 > 1023) ? 1023 : m_reveal + 4;
      end
    end
    if (exp_q.size() >= 3) begin
      check("out_bus", 64'(obs_bus), 64'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    check("pixel_addr", 64'(pixel_addr), 64'(m_addr));
  endtask

  task automatic drive(input int h, input int v, input logic [11:0] c,
                       input bit hb, input bit vb, input bit hs, input bit vs);
    vin.hcount = 11'(h); vin.vcount = 11'(v); vin.rgb = c;
    vin.hblnk = hb; vin.vblnk = vb; vin.hsync = hs; vin.vsync = vs;
  endtask

  task automatic pix(input int h, input int v, input logic [11:0] c);
    drive(h, v, c, 0, 0, 0, 0);
    step();
  endtask

  task automatic tick();
    drive(0, 0, 12'h000, 1, 1, 0, 1); step();
    drive(0, 0, 12'h000, 1, 1, 0, 0); step();
  endtask

  task automatic set_ladder(input int i, input int x, input int t, input int b);
    ladder_x[11*i +: 11] = 11'(x);
    ladder_top[11*i +: 11] = 11'(t);
    ladder_bot[11*i +: 11] = 11'(b);
  endtask

  initial begin
    int          lo, t_all, x, tp;
    logic [10:0] exp_a;
    rst = 1'b1; start_game = 1'b0;
    ladder_x = '0; ladder_top = '0; ladder_bot = '0;
    drive(0, 0, 12'h000, 0, 0, 0, 0);
    m_addr = '0;

    // Reset and pass-through with the game stopped.
    repeat (3) step();
    check("reset_out", 64'(obs_bus), 64'd0);
    check("reset_addr", 64'(pixel_addr), 64'd0);
    rst = 1'b0;
    set_ladder(0, 100, 200, 263);
    for (int i = 1; i < NL; i++) set_ladder(i, 2000, 0, 0);
    for (int k = 0; k < 20; k++) pix($urandom_range(90, 140), $urandom_range(190, 270), 12'h123);
    pix(110, 230, 12'h123);
    drive(0, 0, 12'h123, 1, 0, 0, 0); step();
    pix(5, 5, 12'h123);
    check("idle_passthru_rgb", 64'(vout.rgb), 64'h123);
    pix(6, 5, 12'h123);
    check("idle_blank_rgb", 64'(vout.rgb), 64'h888);
    check("idle_addr_hold", 64'(pixel_addr), 64'd0);
    $display("txn: idle pass-through done");

    // Reveal growth on a single ladder.
    start_game = 1'b1;
    pix(0, 0, 12'h000);
    pix(0, 0, 12'h000);
    for (int t = 1; t <= 20; t++) begin
      tick();
      lo = 264 - 4 * t;
      if (lo >= 200) begin
        pix(100, lo, 12'h321);
        exp_a = {1'((t / 8) % 2), 5'((lo - 200) % 32), 5'd0};
        check("reveal_edge", 64'(pixel_addr), 64'(exp_a));
        pix(101, lo - 1, 12'h321);
        check("reveal_above", 64'(pixel_addr), 64'(exp_a));
      end
      for (int k = 0; k < 6; k++) pix($urandom_range(96, 136), $urandom_range(180, 268), 12'($urandom));
      $display("txn: tick %0d", t);
    end
    for (int v = 180; v <= 205; v++) pix(110, v, 12'h456);
    pix(131, 240, 12'h456);
    check("addr_131_240", 64'(pixel_addr), 64'h11F);
    pix(132, 240, 12'h456);
    check("addr_132_hold", 64'(pixel_addr), 64'h11F);

    // Colour key at one ROM address only.
    pix(105, 240, 12'hABC);
    pix(106, 240, 12'hABC);
    pix(0, 0, 12'h000);
    check("key_passthru", 64'(vout.rgb), 64'hABC);
    pix(0, 1, 12'h000);
    check("key_neighbour", 64'(vout.rgb), 64'h106);
    $display("txn: colour key done");

    // Drop start_game mid-reveal, then restart.
    start_game = 1'b0;
    pix(110, 230, 12'h777);
    for (int v = 200; v <= 263; v += 8) pix(110, v, 12'h777);
    start_game = 1'b1;
    pix(100, 263, 12'h777);
    pix(100, 263, 12'h777);
    check("restart_no_hit", 64'(pixel_addr), 64'h106);
    $display("txn: restart done");

    // Overlap: ladder 0 wins; frame toggles every 8 ticks.
    set_ladder(1, 100, 216, 263);
    for (int t = 1; t <= 16; t++) begin
      tick();
      pix(100, 263, 12'h0F0);
      exp_a = {1'((t / 8) % 2), 5'd31, 5'd0};
      check("overlap_frame", 64'(pixel_addr), 64'(exp_a));
      for (int k = 0; k < 4; k++) pix($urandom_range(96, 136), $urandom_range(200, 268), 12'($urandom));
    end
    $display("txn: overlap/animation done");

    // Saturation at 1023 rows.
    set_ladder(0, 100, 0, 1500);
    for (int t = 0; t < 260; t++) tick();
    t_all = 16 + 260;
    pix(100, 478, 12'h0AA);
    exp_a = {1'((t_all / 8) % 2), 5'd30, 5'd0};
    check("sat_edge", 64'(pixel_addr), 64'(exp_a));
    pix(101, 477, 12'h0AA);
    check("sat_above", 64'(pixel_addr), 64'(exp_a));
    for (int v = 470; v <= 485; v++) pix(105, v, 12'h0AA);
    $display("txn: saturation done");

    // Randomized traffic with a mid-run reset.
    for (int c = 0; c < 1600; c++) begin
      if (c % 200 == 0)
        for (int i = 0; i < NL; i++) begin
          tp = $urandom_range(0, 500);
          set_ladder(i, $urandom_range(0, 700), tp, tp + $urandom_range(0, 300));
        end
      if ($urandom_range(0, 299) == 0) start_game = ~start_game;
      rst = (c == 700 || c == 701);
      if ($urandom_range(0, 1) == 0) begin
        x = int'(ladder_x[11*($urandom_range(0, NL-1)) +: 11]);
        drive(x + $urandom_range(0, 36), $urandom_range(0, 799), 12'($urandom),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
              1'($urandom), ($urandom_range(0, 15) == 0));
      end else begin
        drive($urandom_range(0, 799), $urandom_range(0, 699), 12'($urandom),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
              1'($urandom), ($urandom_range(0, 15) == 0));
      end
      step();
    end
    rst = 1'b0;
    $display("txn: random traffic done");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ladder_sprite_renderer.md
Name: ladder_sprite_renderer

Overview:
- Parametrised ladder overlay stage in the VGA pipeline. Draws NUM_LADDERS vertically tiled ladder sprites from an external synchronous sprite ROM.
- Adds three behaviours: multi-frame animation, a per-game "grow upward" reveal, and colour-key transparency.
- Sits between background/platform drawing and character stages. Consumes and produces vga_if.

Parameters:
- NUM_LADDERS, 4, number of independent ladder instances.
- SPRITE_W, 32, sprite width in pixels (power of 2).
- SPRITE_H, 32, sprite height in pixels (power of 2); the tile repeats vertically.
- ANIM_FRAMES, 2, sprite frames stored in ROM (power of 2, ≥1).
- FRAME_DIV, 8, video frames per animation step.
- REVEAL_STEP, 4, rows revealed per video frame.
- TRANSPARENT, 12'hF0F, colour key; ROM pixels of this value show the underlying rgb.
- BLANK_RGB, 12'h888, rgb driven during blanking.

Ports:
- clk, input, 1, pixel clock.
- rst, input, 1, synchronous active-high reset.
- start_game, input, 1, level; enables drawing and reveal.
- ladder_x, input, NUM_LADDERS*11, left column per ladder; ladder i at bits [11i+10:11i].
- ladder_top, input, NUM_LADDERS*11, topmost row per ladder.
- ladder_bot, input, NUM_LADDERS*11, bottom row per ladder (inclusive; ladder_bot ≥ ladder_top).
- rgb_pixel, input, 12, ROM data; valid 1 clk after pixel_addr.
- pixel_addr, output, AW = log2(ANIM_FRAMES)+log2(SPRITE_H)+log2(SPRITE_W), {frame, row, col}.
- in, vga_if.in, -, incoming timing + rgb.
- out, vga_if.out, -, outgoing timing + rgb.

Behaviour:
- Reset: out.* = 0, pixel_addr = 0, frame_idx = 0, div_cnt = 0, reveal = 0, state = IDLE.
- Latency: out.* is exactly 3 clk behind in.* for every field, including hcount/vcount/sync/blnk.
  - Stage 1: hit detect on in.*, pixel_addr registered.
  - Stage 2: ROM returns rgb_pixel; timing, hit flag and in.rgb delayed to match.
  - Stage 3: output register.
- Hit for ladder i, all required:
  - start_game = 1;
  - ladder_x[i] ≤ hcount < ladder_x[i]+SPRITE_W;
  - max(ladder_top[i], ladder_bot[i]−reveal+1) ≤ vcount ≤ ladder_bot[i];
  - reveal > 0.
- Overlapping hits: lowest index i wins.
- Address for a hit:
  - col = (hcount − ladder_x[i])[log2 W−1:0];
  - row = (vcount − ladder_top[i])[log2 H−1:0], i.e. the tile wraps every SPRITE_H rows;
  - frame = frame_idx.
- No hit: pixel_addr holds its previous value.
- Stage-3 rgb, in priority order:
  - blank (vblnk|hblnk delayed): BLANK_RGB;
  - hit and rgb_pixel ≠ TRANSPARENT: rgb_pixel;
  - otherwise: delayed in.rgb.
- Frame tick = rising edge of in.vsync, detected with a registered copy.
- Animation (only while start_game):
  - div_cnt increments on each tick;
  - at FRAME_DIV−1 it wraps to 0 and frame_idx advances modulo ANIM_FRAMES;
  - ANIM_FRAMES = 1 means the frame field is absent and frame_idx is constant 0.
- Reveal FSM (reveal is 11-bit, saturating):
  - IDLE: reveal = 0. start_game = 1 → REVEAL.
  - REVEAL: each tick reveal += REVEAL_STEP. When the next value would be ≥ 1024, clamp to 1023 → SHOWN.
  - SHOWN: reveal held at 1023.
  - start_game = 0 in any state → IDLE next clk; reveal, frame_idx and div_cnt cleared.
- Position inputs are sampled at stage 1 each clk. Changes take effect on the next pixel; no shadowing.
- Reset mid-frame: outputs 0 for the reset clk(s). Pipeline refills, so out is valid 3 clk after rst falls.

Decomposition:
- vgaPkg holds:
  - ladder_state_t enum {IDLE, REVEAL, SHOWN};
  - TRANSPARENT_DEFAULT;
  - BLANK_RGB_DEFAULT;
  - VER_PIXELS.
- Timing alignment reuses the existing delay sub-module, WIDTH = 38 + 1 hit bit, CLK_DEL = 2.
- Hit/priority logic is a for-loop inside this module; no further sub-modules.

Test Plan:
- Reset, then start_game = 0 with in.rgb = 12'h123 active → out.rgb = 12'h123 at 3 clk latency; 12'h888 in blanking; pixel_addr never changes.
- start_game = 1; ladder0 x = 100, top = 200, bot = 263; run 20 vsync ticks → reveal = 80. Row 263 and row 184 limits are clamped by top, so rows 200..263 drawn, rows <200 not. Check reveal growth at ticks 1..16.
- Pixel (hcount = 131, vcount = 240), ROM model returns the address LSBs → pixel_addr = {frame, 5'd8, 5'd31}. hcount = 132 → no hit.
- ROM returns 12'hF0F for one address → underlying in.rgb passes through at that pixel only.
- Ladders 0 and 1 overlapping at x = 100 → ladder 0's address is used. Run 16 ticks → frame_idx toggles at ticks 8 and 16.
- Deassert start_game mid-REVEAL → next clk state = IDLE, reveal = 0. No hits until re-assert, then reveal restarts from 0.
